game_flow_ctrl: RTL and testbench



---
 rtl/game_pkg.sv | 65 ++++++
 rtl/game_flow_ctrl_menu_hit_decoder.sv | 58 +++++
 rtl/game_flow_ctrl.sv | 164 ++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared encodings, overlay button geometry and helpers for the maze game flow controller.
package game_pkg;

    typedef enum logic [3:0] {
        ST_TITLE    = 4'd0,
        ST_STAFF    = 4'd1,
        ST_STAGE1   = 4'd2,
        ST_SUCCESS1 = 4'd3,
        ST_STAGE2   = 4'd4,
        ST_SUCCESS2 = 4'd5,
        ST_STAGE3   = 4'd6,
        ST_SUCCESS3 = 4'd7,
        ST_FAIL     = 4'd8,
        ST_HELP     = 4'd9
    } state_e;

    typedef enum logic [1:0] {
        TODO_NONE       = 2'd0,
        TODO_FIND_KEY   = 2'd1,
        TODO_FIND_LIGHT = 2'd2,
        TODO_FIND_DOOR  = 2'd3
    } todo_e;

    // One-hot button identifiers produced by the hit decoder.
    localparam logic [6:0] BTN_NONE   = 7'b000_0000;
    localparam logic [6:0] BTN_STAGE1 = 7'b000_0001;
    localparam logic [6:0] BTN_STAGE2 = 7'b000_0010;
    localparam logic [6:0] BTN_STAGE3 = 7'b000_0100;
    localparam logic [6:0] BTN_HELP   = 7'b000_1000;
    localparam logic [6:0] BTN_NEXT   = 7'b001_0000;
    localparam logic [6:0] BTN_BACK   = 7'b010_0000;
    localparam logic [6:0] BTN_RETRY  = 7'b100_0000;

    // All buttons share one column; rows are half-open [lo,hi) in 320x240 space.
    localparam logic [8:0] BTN_X_LO       = 9'd120;
    localparam logic [8:0] BTN_X_HI       = 9'd200;
    localparam logic [8:0] Y_TITLE_S1_LO  = 9'd120;
    localparam logic [8:0] Y_TITLE_S1_HI  = 9'd140;
    localparam logic [8:0] Y_TITLE_S2_LO  = 9'd150;
    localparam logic [8:0] Y_TITLE_S2_HI  = 9'd170;
    localparam logic [8:0] Y_TITLE_S3_LO  = 9'd180;
    localparam logic [8:0] Y_TITLE_S3_HI  = 9'd200;
    localparam logic [8:0] Y_TITLE_HLP_LO = 9'd210;
    localparam logic [8:0] Y_TITLE_HLP_HI = 9'd230;
    localparam logic [8:0] Y_NEXT_LO      = 9'd140;
    localparam logic [8:0] Y_NEXT_HI      = 9'd160;
    localparam logic [8:0] Y_BACK_LO      = 9'd180;
    localparam logic [8:0] Y_BACK_HI      = 9'd200;
    localparam logic [8:0] Y_STAFF_LO     = 9'd150;
    localparam logic [8:0] Y_STAFF_HI     = 9'd170;
    localparam logic [8:0] Y_HELP_BK_LO   = 9'd200;
    localparam logic [8:0] Y_HELP_BK_HI   = 9'd220;

    localparam int START_LIFE_DEF = 3;

    function automatic logic in_range(input logic [8:0] v, input logic [8:0] lo,
                                      input logic [8:0] hi);
        return (v >= lo) && (v < hi);
    endfunction

    function automatic logic is_stage(input state_e s);
        return (s == ST_STAGE1) || (s == ST_STAGE2) || (s == ST_STAGE3);
    endfunction

endpackage

// File: rtl/game_flow_ctrl_menu_hit_decoder.sv
// Maps a cursor position to the one-hot button it lies on for the current screen.
module menu_hit_decoder
    import game_pkg::*;
(
    input  state_e     state_i,
    input  logic [8:0] cur_x_i,
    input  logic [8:0] cur_y_i,
    input  logic [3:0] play_valid_i,
    output logic [6:0] btn_o
);

    logic in_x_s;
    assign in_x_s = in_range(cur_x_i, BTN_X_LO, BTN_X_HI);

    // Screen-dependent row lookup; locked stage buttons decode as no button.
    always_comb begin
        btn_o = BTN_NONE;
        if (in_x_s) begin
            case (state_i)
                ST_TITLE: begin
                    if (in_range(cur_y_i, Y_TITLE_S1_LO, Y_TITLE_S1_HI)) btn_o = BTN_STAGE1;
                    else if (in_range(cur_y_i, Y_TITLE_S2_LO, Y_TITLE_S2_HI) && play_valid_i[2])
                        btn_o = BTN_STAGE2;
                    else if (in_range(cur_y_i, Y_TITLE_S3_LO, Y_TITLE_S3_HI) && play_valid_i[3])
                        btn_o = BTN_STAGE3;
                    else if (in_range(cur_y_i, Y_TITLE_HLP_LO, Y_TITLE_HLP_HI)) btn_o = BTN_HELP;
                    else btn_o = BTN_NONE;
                end
                ST_SUCCESS1, ST_SUCCESS2: begin
                    if (in_range(cur_y_i, Y_NEXT_LO, Y_NEXT_HI)) btn_o = BTN_NEXT;
                    else if (in_range(cur_y_i, Y_BACK_LO, Y_BACK_HI)) btn_o = BTN_BACK;
                    else btn_o = BTN_NONE;
                end
                ST_SUCCESS3: begin
                    if (in_range(cur_y_i, Y_STAFF_LO, Y_STAFF_HI)) btn_o = BTN_NEXT;
                    else btn_o = BTN_NONE;
                end
                ST_FAIL: begin
                    if (in_range(cur_y_i, Y_NEXT_LO, Y_NEXT_HI)) btn_o = BTN_RETRY;
                    else if (in_range(cur_y_i, Y_BACK_LO, Y_BACK_HI)) btn_o = BTN_BACK;
                    else btn_o = BTN_NONE;
                end
                ST_STAFF: begin
                    if (in_range(cur_y_i, Y_BACK_LO, Y_BACK_HI)) btn_o = BTN_BACK;
                    else btn_o = BTN_NONE;
                end
                ST_HELP: begin
                    if (in_range(cur_y_i, Y_HELP_BK_LO, Y_HELP_BK_HI)) btn_o = BTN_BACK;
                    else btn_o = BTN_NONE;
                end
                default: btn_o = BTN_NONE;
            endcase
        end else begin
            btn_o = BTN_NONE;
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Maze game flow FSM: menu navigation, stage objectives, lives and unlock bits.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int INVULN_CYCLES = 25_000_000,
    parameter int START_LIFE    = START_LIFE_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       click,
    input  logic [8:0] cur_x,
    input  logic [8:0] cur_y,
    input  logic       key_pick,
    input  logic       light_pick,
    input  logic       door_touch,
    input  logic       hit,
    input  logic       esc,
    output logic [3:0] state,
    output logic [1:0] key_find,
    output logic [1:0] life,
    output logic [1:0] todo,
    output logic [3:0] play_valid,
    output logic       stage_start
);

    localparam int              CNT_W    = $clog2(INVULN_CYCLES) + 1;
    localparam logic [CNT_W-1:0] INV_LOAD = CNT_W'(INVULN_CYCLES - 1);
    localparam logic [CNT_W-1:0] INV_ZERO = '0;
    localparam logic [1:0]       LIFE0    = 2'(START_LIFE);

    state_e           state_q, state_d;
    todo_e            todo_q, todo_d;
    logic [1:0]       key_q, key_d;
    logic [1:0]       life_q, life_d;
    logic [3:0]       pv_q, pv_d;
    logic             start_q, start_d;
    logic [CNT_W-1:0] inv_q, inv_d;
    logic [6:0]       btn_s;

    menu_hit_decoder u_hit (
        .state_i      (state_q),
        .cur_x_i      (cur_x),
        .cur_y_i      (cur_y),
        .play_valid_i (pv_q),
        .btn_o        (btn_s)
    );

    // State and datapath registers; everything the overlay sees comes from here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_TITLE;
            todo_q  <= TODO_NONE;
            key_q   <= 2'd0;
            life_q  <= LIFE0;
            pv_q    <= 4'b0010;
            start_q <= 1'b0;
            inv_q   <= INV_ZERO;
        end else begin
            state_q <= state_d;
            todo_q  <= todo_d;
            key_q   <= key_d;
            life_q  <= life_d;
            pv_q    <= pv_d;
            start_q <= start_d;
            inv_q   <= inv_d;
        end
    end

    // Next-state logic: menu clicks, then prioritised stage events, then entry/exit effects.
    always_comb begin
        state_d = state_q;
        todo_d  = todo_q;
        key_d   = key_q;
        life_d  = life_q;
        pv_d    = pv_q;
        start_d = 1'b0;
        inv_d   = (inv_q != INV_ZERO) ? (inv_q - CNT_W'(1)) : INV_ZERO;

        case (state_q)
            ST_STAGE1, ST_STAGE2, ST_STAGE3: begin
                if (esc) begin
                    state_d = ST_TITLE;
                end else if (door_touch) begin
                    if (todo_q == TODO_FIND_DOOR) begin
                        case (state_q)
                            ST_STAGE1: begin state_d = ST_SUCCESS1; pv_d[2] = 1'b1; end
                            ST_STAGE2: begin state_d = ST_SUCCESS2; pv_d[3] = 1'b1; end
                            default:   state_d = ST_SUCCESS3;
                        endcase
                    end else begin
                        state_d = state_q;
                    end
                end else if (hit && (state_q == ST_STAGE3)) begin
                    if (inv_q != INV_ZERO) begin
                        life_d = life_q;
                    end else if (life_q > 2'd1) begin
                        life_d = life_q - 2'd1;
                        inv_d  = INV_LOAD;
                    end else begin
                        life_d  = 2'd0;
                        state_d = ST_FAIL;
                    end
                end else if (key_pick) begin
                    if ((todo_q == TODO_FIND_KEY) && (key_q != 2'd3)) begin
                        key_d = key_q + 2'd1;
                        if (key_q == 2'd2) todo_d = TODO_FIND_DOOR;
                        else todo_d = todo_q;
                    end else begin
                        key_d = key_q;
                    end
                end else if (light_pick) begin
                    if (todo_q == TODO_FIND_LIGHT) todo_d = TODO_FIND_KEY;
                    else todo_d = todo_q;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                if (click) begin
                    case (btn_s)
                        BTN_STAGE1: state_d = ST_STAGE1;
                        BTN_STAGE2: state_d = ST_STAGE2;
                        BTN_STAGE3: state_d = ST_STAGE3;
                        BTN_HELP:   state_d = ST_HELP;
                        BTN_BACK:   state_d = ST_TITLE;
                        BTN_RETRY:  state_d = ST_STAGE3;
                        BTN_NEXT: begin
                            case (state_q)
                                ST_SUCCESS1: state_d = ST_STAGE2;
                                ST_SUCCESS2: state_d = ST_STAGE3;
                                ST_SUCCESS3: state_d = ST_STAFF;
                                default:     state_d = state_q;
                            endcase
                        end
                        default: state_d = state_q;
                    endcase
                end else begin
                    state_d = state_q;
                end
            end
        endcase

        // Stages are only entered from menus and only left for menus.
        if (is_stage(state_d) && !is_stage(state_q)) begin
            key_d   = 2'd0;
            life_d  = LIFE0;
            inv_d   = INV_ZERO;
            start_d = 1'b1;
            todo_d  = (state_d == ST_STAGE2) ? TODO_FIND_LIGHT : TODO_FIND_KEY;
        end else if (!is_stage(state_d) && is_stage(state_q)) begin
            todo_d = TODO_NONE;
        end else begin
            start_d = 1'b0;
        end
    end

    assign state       = state_q;
    assign key_find    = key_q;
    assign life        = life_q;
    assign todo        = todo_q;
    assign play_valid  = pv_q;
    assign stage_start = start_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with a short invulnerability window.
module tb_game_flow_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       click, key_pick, light_pick, door_touch, hit, esc;
    logic [8:0] cur_x, cur_y;
    logic [3:0] state, play_valid;
    logic [1:0] key_find, life, todo;
    logic       stage_start;

    int checks   = 0;
    int failures = 0;

    game_flow_ctrl #(.INVULN_CYCLES(4), .START_LIFE(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .click       (click),
        .cur_x       (cur_x),
        .cur_y       (cur_y),
        .key_pick    (key_pick),
        .light_pick  (light_pick),
        .door_touch  (door_touch),
        .hit         (hit),
        .esc         (esc),
        .state       (state),
        .key_find    (key_find),
        .life        (life),
        .todo        (todo),
        .play_valid  (play_valid),
        .stage_start (stage_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One cycle of stimulus: inputs set at negedge, outputs sampled 1ns after posedge.
    task automatic step(input logic c, input int x, input int y, input logic k,
                        input logic l, input logic d, input logic h, input logic e);
        @(negedge clk);
        click = c; cur_x = 9'(x); cur_y = 9'(y);
        key_pick = k; light_pick = l; door_touch = d; hit = h; esc = e;
        @(posedge clk);
        #1;
        click = 1'b0; key_pick = 1'b0; light_pick = 1'b0;
        door_touch = 1'b0; hit = 1'b0; esc = 1'b0;
    endtask

    task automatic clk_at(input int x, input int y);
        step(1'b1, x, y, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; click = 1'b0; cur_x = 9'd0; cur_y = 9'd0;
        key_pick = 1'b0; light_pick = 1'b0; door_touch = 1'b0; hit = 1'b0; esc = 1'b0;
        #12;
        chk("rst_state", state, 0);
        chk("rst_key", key_find, 0);
        chk("rst_life", life, 3);
        chk("rst_todo", todo, 0);
        chk("rst_pv", play_valid, 4'b0010);
        chk("rst_start", stage_start, 0);
        @(negedge clk); rst_n = 1'b1;

        clk_at(150, 160); chk("locked_s2", state, 0);
        clk_at(100, 125); chk("outside_x", state, 0);
        clk_at(150, 140); chk("edge_y140", state, 0);
        clk_at(150, 125);
        chk("s1_state", state, 2); chk("s1_todo", todo, 1);
        chk("s1_key", key_find, 0); chk("s1_life", life, 3); chk("s1_start", stage_start, 1);
        idle(1); chk("s1_start_off", stage_start, 0);
        clk_at(150, 185); chk("stage_click", state, 2);

        step(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); chk("k1", key_find, 1); chk("k1_todo", todo, 1);
        step(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); chk("k2", key_find, 2);
        step(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); chk("k3", key_find, 3); chk("k3_todo", todo, 3);
        step(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); chk("k_sat", key_find, 3);
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("succ1", state, 3); chk("succ1_pv", play_valid, 4'b0110);
        chk("succ1_todo", todo, 0); chk("succ1_key", key_find, 3);

        clk_at(150, 145); chk("s2_state", state, 4); chk("s2_todo", todo, 2); chk("s2_key", key_find, 0);
        step(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); chk("s2_key_early", key_find, 0);
        step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); chk("s2_light", todo, 1);
        for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("s2_keys", key_find, 3); chk("s2_todo_door", todo, 3);
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("succ2", state, 5); chk("succ2_pv", play_valid, 4'b1110);

        clk_at(150, 145); chk("s3_state", state, 6); chk("s3_todo", todo, 1); chk("s3_life", life, 3);
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); chk("hit1", life, 2);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); chk("hit_invuln", life, 2);
        end
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); chk("hit2", life, 1);
        idle(3);
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("fail_state", state, 8); chk("fail_life", life, 0); chk("fail_todo", todo, 0);

        clk_at(150, 145); chk("retry_state", state, 6); chk("retry_life", life, 3);
        chk("retry_start", stage_start, 1);
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); idle(3);
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); chk("life1", life, 1);
        for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("s3_todo_door", todo, 3);
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("door_over_hit", state, 7); chk("door_over_hit_life", life, 1);
        chk("succ3_pv", play_valid, 4'b1110);

        clk_at(150, 155); chk("staff", state, 1);
        clk_at(150, 185); chk("staff_back", state, 0);
        clk_at(150, 155); chk("s2_unlocked", state, 4);
        step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); chk("pre_esc_key", key_find, 1);
        step(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("esc_state", state, 0); chk("esc_key", key_find, 1); chk("esc_todo", todo, 0);

        clk_at(150, 215); chk("help", state, 9);
        clk_at(150, 225); chk("help_miss", state, 9);
        clk_at(150, 205); chk("help_back", state, 0);

        clk_at(150, 185); chk("s3_unlocked", state, 6);
        step(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); chk("pre_rst_key", key_find, 1);
        @(negedge clk); rst_n = 1'b0; #1;
        chk("arst_state", state, 0); chk("arst_pv", play_valid, 4'b0010);
        chk("arst_todo", todo, 0); chk("arst_life", life, 3); chk("arst_key", key_find, 0);
        @(negedge clk); rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
